// File: rtl/flash_arbiter_pkg.sv
// Shared types and constants for the two-port flash read arbiter.
package flash_arbiter_pkg;
  localparam int WADDR_W = 16;
  localparam int FADDR_W = 24;

  localparam logic [FADDR_W-1:0] BASE0_DEF = 24'h100000;
  localparam logic [FADDR_W-1:0] BASE1_DEF = 24'h180000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word address to flash byte address; the add wraps at 2^24.
  function automatic logic [FADDR_W-1:0] flash_byte_addr(
    input logic [FADDR_W-1:0] base,
    input logic [WADDR_W-1:0] waddr
  );
    return base + {{(FADDR_W-WADDR_W-1){1'b0}}, waddr, 1'b0};
  endfunction
endpackage

// File: rtl/flash_rr_arb2.sv
// Two-requester round-robin grant; the port not served last wins a tie.
module flash_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       served_vld,
  input  logic       served_port,
  output logic       gnt_vld,
  output logic       gnt_port
);
  logic last;

  assign gnt_vld  = |req;
  assign gnt_port = (req == 2'b11) ? ~last : req[1];

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset_n)        last <= 1'b1;
    else if (served_vld) last <= served_port;
  end
endmodule

// File: rtl/flash_arbiter.sv
// Two ports share one flash reader; each port has a one-entry hit register.
module flash_arbiter
  import flash_arbiter_pkg::*;
#(
  parameter logic [FADDR_W-1:0] BASE0 = BASE0_DEF,
  parameter logic [FADDR_W-1:0] BASE1 = BASE1_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0,
  input  logic               req1,
  input  logic [WADDR_W-1:0] addr0,
  input  logic [WADDR_W-1:0] addr1,
  output logic               ack0,
  output logic               ack1,
  output logic [WADDR_W-1:0] rdata0,
  output logic [WADDR_W-1:0] rdata1,
  input  logic               inval,
  output logic               busy,
  output logic               flash_hold,
  output logic [FADDR_W-1:0] flash_addr,
  input  logic               flash_ready,
  input  logic [15:0]        flash_rdata
);
  state_t state;
  logic owner, inval_seen;
  logic [WADDR_W-1:0] lat_addr, resp_data;
  logic [1:0] hit_vld;
  logic [1:0][WADDR_W-1:0] hit_addr, hit_data, addr_v;
  logic [1:0] req_v;
  logic gnt_vld, gnt_port, hit;

  assign req_v  = {req1, req0};
  assign addr_v = {addr1, addr0};
  assign busy   = (state != IDLE);
  // A same-cycle inval already counts against the lookup.
  assign hit    = hit_vld[gnt_port] && !inval && (hit_addr[gnt_port] == addr_v[gnt_port]);

  flash_rr_arb2 u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req_v),
    .served_vld (state == RESP),
    .served_port(owner),
    .gnt_vld    (gnt_vld),
    .gnt_port   (gnt_port)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      inval_seen <= 1'b0;
      lat_addr   <= '0;
      resp_data  <= '0;
      hit_vld    <= '0;
      hit_addr   <= '0;
      hit_data   <= '0;
      flash_hold <= 1'b1;
      flash_addr <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: if (gnt_vld) begin
          owner    <= gnt_port;
          lat_addr <= addr_v[gnt_port];
          if (hit) begin
            resp_data <= hit_data[gnt_port];
            state     <= RESP;
          end else begin
            flash_addr <= flash_byte_addr(gnt_port ? BASE1 : BASE0, addr_v[gnt_port]);
            flash_hold <= 1'b0;
            inval_seen <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (inval) inval_seen <= 1'b1;
          if (flash_ready) begin
            resp_data       <= flash_rdata;
            flash_hold      <= 1'b1;
            // A fill overtaken by inval still answers but is not trusted later.
            hit_vld[owner]  <= !(inval || inval_seen);
            hit_addr[owner] <= lat_addr;
            hit_data[owner] <= flash_rdata;
            state           <= RESP;
          end
        end
        RESP: begin
          if (owner) begin
            ack1   <= 1'b1;
            rdata1 <= resp_data;
          end else begin
            ack0   <= 1'b1;
            rdata0 <= resp_data;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (inval) hit_vld <= '0;
    end
  end
endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a scoreboard of expected acks.
module tb_flash_arbiter;
  localparam logic [23:0] B0 = 24'h100000;
  localparam logic [23:0] B1 = 24'h180000;
  localparam int MISS_LAT = 72;
  localparam int HIT_LAT  = 2;

  typedef struct {
    bit          port;
    logic [15:0] data;
  } exp_t;

  logic clk, reset_n, req0, req1, inval, flash_ready;
  logic [15:0] addr0, addr1, flash_rdata, rdata0, rdata1;
  logic ack0, ack1, busy, flash_hold;
  logic [23:0] flash_addr;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  int fl_cnt = 0;
  int txn = 0;
  bit prev_hold = 1'b1;
  logic [23:0] last_faddr = '0;

  bit mon_rs;
  logic [15:0] prev_rd0 = '0, prev_rd1 = '0;

  flash_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1), .inval(inval), .busy(busy),
    .flash_hold(flash_hold), .flash_addr(flash_addr),
    .flash_ready(flash_ready), .flash_rdata(flash_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_faddr(input bit p, input logic [15:0] a);
    return (p ? B1 : B0) + {7'b0, a, 1'b0};
  endfunction

  function automatic logic [15:0] model_data(input bit p, input logic [15:0] a);
    logic [23:0] f;
    f = model_faddr(p, a);
    return f[15:0] ^ 16'hA5A5;
  endfunction

  // Flash reader model: ready 70 cycles after hold falls, data = addr ^ A5A5.
  always @(negedge clk) begin
    if (!flash_hold && prev_hold) begin
      txn++;
      last_faddr = flash_addr;
    end
    prev_hold = (flash_hold !== 1'b0);
    if (flash_hold !== 1'b0) begin
      fl_cnt = 0;
      flash_ready = 1'b0;
    end else begin
      fl_cnt++;
      flash_ready = (fl_cnt == 70);
      flash_rdata = flash_addr[15:0] ^ 16'hA5A5;
    end
  end

  // Output monitor: pops the scoreboard on each ack, checks rdata holds otherwise.
  always @(posedge clk) begin
    exp_t e;
    mon_rs = reset_n;
    #1;
    if (ack0 === 1'b1 && ack1 === 1'b1) chk("one_ack", {ack1, ack0}, 32'd1);
    if (ack0 === 1'b1 || ack1 === 1'b1) begin
      chk("ack_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_port", ack1, e.port);
        chk("rdata", ack1 ? rdata1 : rdata0, e.data);
      end
    end
    if (mon_rs) begin
      if (ack0 !== 1'b1) chk("rdata0_hold", rdata0, prev_rd0);
      if (ack1 !== 1'b1) chk("rdata1_hold", rdata1, prev_rd1);
    end
    prev_rd0 = rdata0;
    prev_rd1 = rdata1;
  end

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; inval = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    reset_n = 1'b1;
  endtask

  task automatic request(input bit p, input logic [15:0] a, input int exp_lat,
                         input int exp_txn, input int inval_at);
    int lat, t0;
    bit hold_low;
    exp_t e;
    t0 = txn;
    e.port = p;
    e.data = model_data(p, a);
    sb.push_back(e);
    if (p) begin req1 = 1'b1; addr1 = a; end
    else   begin req0 = 1'b1; addr0 = a; end
    lat = 0;
    hold_low = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      inval = (lat == inval_at);
      if (flash_hold === 1'b0) hold_low = 1;
      if ((p ? ack1 : ack0) === 1'b1 || lat >= 200) break;
    end
    req0 = 1'b0; req1 = 1'b0; inval = 1'b0;
    chk("latency", lat, exp_lat);
    chk("flash_txns", txn - t0, exp_txn);
    if (exp_txn == 0) chk("hold_stays_high", hold_low, 0);
    else              chk("flash_addr", last_faddr, model_faddr(p, a));
  endtask

  task automatic pair(input logic [15:0] a0, input logic [15:0] a1, input int exp_txn);
    int t0, n;
    bit d0, d1;
    exp_t e;
    t0 = txn;
    e.port = 1'b0; e.data = model_data(1'b0, a0); sb.push_back(e);
    e.port = 1'b1; e.data = model_data(1'b1, a1); sb.push_back(e);
    req0 = 1'b1; addr0 = a0;
    req1 = 1'b1; addr1 = a1;
    d0 = 0; d1 = 0; n = 0;
    while (!(d0 && d1) && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (ack0 === 1'b1) begin req0 = 1'b0; d0 = 1; end
      if (ack1 === 1'b1) begin req1 = 1'b0; d1 = 1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("pair_done", {d1, d0}, 32'd3);
    chk("pair_txns", txn - t0, exp_txn);
  endtask

  initial begin
    addr0 = '0; addr1 = '0;
    do_reset(3);
    chk("rst_hold", flash_hold, 1);
    chk("rst_faddr", flash_addr, 0);
    chk("rst_acks", {ack1, ack0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", {rdata1, rdata0}, 0);

    // Miss then hit on the same port-0 address.
    request(1'b0, 16'h0010, MISS_LAT, 1, 0);
    request(1'b0, 16'h0010, HIT_LAT, 0, 0);
    request(1'b1, 16'h0001, MISS_LAT, 1, 0);
    request(1'b1, 16'hFFFF, MISS_LAT, 1, 0);
    repeat (3) begin @(posedge clk); #1; end

    // Simultaneous requests after reset: both miss, then both hit, port 0 first each time.
    do_reset(1);
    pair(16'h0010, 16'h0001, 2);
    pair(16'h0010, 16'h0001, 0);

    // inval during the fill: ack still comes, but the line is not cached.
    request(1'b0, 16'h0020, MISS_LAT, 1, 10);
    request(1'b0, 16'h0020, MISS_LAT, 1, 0);
    request(1'b0, 16'h0020, HIT_LAT, 0, 0);

    // Reset 30 cycles into a fill abandons it.
    req0 = 1'b1; addr0 = 16'h0030;
    repeat (31) begin @(posedge clk); #1; end
    chk("busy_in_fill", busy, 1);
    chk("fill_faddr", flash_addr, 24'h100060);
    reset_n = 1'b0; req0 = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("abort_hold", flash_hold, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ack", {ack1, ack0}, 0);
    repeat (80) begin @(posedge clk); #1; end
    request(1'b0, 16'h0030, MISS_LAT, 1, 0);
    request(1'b0, 16'h0020, MISS_LAT, 1, 0);

    repeat (3) begin @(posedge clk); #1; end
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
